fifo_fill_sequencer: RTL and testbench

- Sequences the existing `fifo_filler` across a bank of NUM_FIFOS byte FIFOs:
  - drives its address and start pulse;
  - steers its write strobe to the selected FIFO and returns that FIFO's full flag;
  - watches for a stalled fill.
- After a fill pass, drains one selected FIFO on request and packs its DEPTH bytes into one word for the checker/consumer.
- Sits between the top-level control and the filler/FIFO bank, replacing the hand-sequencing previously done in benches.

---
 rtl/fifo_fill_pkg.sv | 24 ++
 rtl/fifo_drain_packer.sv | 51 +++++
 rtl/fifo_fill_sequencer.sv | 147 ++++++++++++++
 tb/tb_fifo_fill_sequencer.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fill_pkg.sv
// Shared types and defaults for the FIFO fill/drain sequencer.
package fifo_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } fill_state_e;

  localparam int DEF_NUM_FIFOS   = 9;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_ADDR_BASE   = 0;
  localparam int DEF_ADDR_STRIDE = 1;
  localparam int DEF_TIMEOUT     = 1000;

  // Index width for n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_packer.sv
// Shifts drained bytes in from the top so the first byte ends in [7:0];
// publishes the packed word with a one-cycle valid after DEPTH captures.
module fifo_drain_packer
  import fifo_fill_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_i,
  input  logic [7:0]         byte_i,
  output logic               last_o,
  output logic [DEPTH*8-1:0] word_o,
  output logic               valid_o
);

  localparam int CW = idx_w(DEPTH);

  logic [CW-1:0]      cnt_q;
  logic [DEPTH*8-1:0] shadow_q;
  logic [DEPTH*8-1:0] shadow_d;
  logic [DEPTH*8-1:0] word_q;
  logic               valid_q;

  assign shadow_d = {byte_i, shadow_q[DEPTH*8-1:8]};
  assign last_o   = cap_i && (cnt_q == CW'(DEPTH - 1));
  assign word_o   = word_q;
  assign valid_o  = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cap_i) begin
        shadow_q <= shadow_d;
        if (last_o) begin
          cnt_q   <= '0;
          word_q  <= shadow_d;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_fill_sequencer.sv
// Walks the fifo_filler over every FIFO in the bank, steering its strobe and
// full flag, flags stalls, and drains one FIFO into a packed word on request.
module fifo_fill_sequencer
  import fifo_fill_pkg::*;
#(
  parameter int                NUM_FIFOS   = DEF_NUM_FIFOS,
  parameter int                DEPTH       = DEF_DEPTH,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = ADDR_W'(DEF_ADDR_BASE),
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(DEF_ADDR_STRIDE),
  parameter int                TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          go,
  output logic                          busy,
  output logic                          fill_done,
  output logic                          timeout_err,
  output logic [idx_w(NUM_FIFOS)-1:0]   cur_idx,
  output logic                          filler_start,
  output logic [ADDR_W-1:0]             filler_address,
  input  logic                          filler_wren,
  input  logic                          filler_done,
  output logic                          filler_full,
  output logic [NUM_FIFOS-1:0]          fifo_wren,
  input  logic [NUM_FIFOS-1:0]          fifo_full,
  output logic [NUM_FIFOS-1:0]          fifo_rden,
  input  logic [NUM_FIFOS*8-1:0]        fifo_rdata,
  input  logic                          rd_req,
  input  logic [idx_w(NUM_FIFOS)-1:0]   rd_idx,
  output logic [DEPTH*8-1:0]            rd_word,
  output logic                          rd_valid,
  output fill_state_e                   dbg_state
);

  localparam int IDX_W = idx_w(NUM_FIFOS);
  localparam int TW    = idx_w(TIMEOUT);
  localparam int RCW   = $clog2(DEPTH + 1);

  fill_state_e state_q;
  logic [IDX_W-1:0] cur_idx_q;
  logic [TW-1:0]    timer_q;
  logic [RCW-1:0]   rden_cnt_q;
  logic             fill_done_q;
  logic             timeout_err_q;
  logic             cap_q;

  logic       go_ok;
  logic       rd_ok;
  logic       filling;
  logic       rden_on;
  logic       pack_last;
  logic [7:0] drain_byte;

  assign go_ok   = go && ((state_q == ST_IDLE) || (state_q == ST_ERR));
  assign rd_ok   = rd_req && !go && (state_q == ST_IDLE) && (int'(rd_idx) < NUM_FIFOS);
  assign filling = (state_q == ST_START) || (state_q == ST_WAIT);
  assign rden_on = (state_q == ST_DRAIN) && (rden_cnt_q != RCW'(DEPTH));

  assign busy           = filling || (state_q == ST_DRAIN);
  assign filler_start   = (state_q == ST_START);
  assign fill_done      = fill_done_q;
  assign timeout_err    = timeout_err_q;
  assign cur_idx        = cur_idx_q;
  assign filler_address = ADDR_BASE + ADDR_W'(cur_idx_q) * ADDR_STRIDE;
  assign dbg_state      = state_q;

  always_comb begin
    fifo_wren   = '0;
    fifo_rden   = '0;
    filler_full = 1'b0;
    drain_byte  = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (cur_idx_q == IDX_W'(i)) begin
        fifo_wren[i] = filling && filler_wren;
        fifo_rden[i] = rden_on;
        filler_full  = fifo_full[i];
        drain_byte   = fifo_rdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cur_idx_q     <= '0;
      timer_q       <= '0;
      rden_cnt_q    <= '0;
      fill_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cap_q         <= 1'b0;
    end else begin
      // FIFO read data trails its rden by one cycle, so capture trails too.
      cap_q <= rden_on;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (go_ok) begin
            cur_idx_q     <= '0;
            fill_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            state_q       <= ST_START;
          end else if (rd_ok) begin
            cur_idx_q  <= rd_idx;
            rden_cnt_q <= '0;
            state_q    <= ST_DRAIN;
          end
        end
        ST_START: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (filler_done) begin
            if (cur_idx_q == IDX_W'(NUM_FIFOS - 1)) begin
              fill_done_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              cur_idx_q <= cur_idx_q + IDX_W'(1);
              state_q   <= ST_START;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= ST_ERR;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (rden_on) rden_cnt_q <= rden_cnt_q + RCW'(1);
          if (pack_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fifo_drain_packer #(.DEPTH(DEPTH)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap_i   (cap_q),
    .byte_i  (drain_byte),
    .last_o  (pack_last),
    .word_o  (rd_word),
    .valid_o (rd_valid)
  );

endmodule

// File: tb/tb_fifo_fill_sequencer.sv
// Bench for fifo_fill_sequencer: behavioural filler and FIFO bank, scoreboarded drains.
module tb_fifo_fill_sequencer;
  import fifo_fill_pkg::*;

  localparam int NF      = 9;
  localparam int DEPTH   = 8;
  localparam int AW      = 32;
  localparam int TIMEOUT = 1000;
  localparam int IW      = 4;
  localparam int WW      = DEPTH * 8;

  logic          clk;
  logic          rst_n;
  logic          go;
  logic          busy;
  logic          fill_done;
  logic          timeout_err;
  logic [IW-1:0] cur_idx;
  logic          filler_start;
  logic [AW-1:0] filler_address;
  logic          filler_wren;
  logic          filler_done;
  logic          filler_full;
  logic [NF-1:0] fifo_wren;
  logic [NF-1:0] fifo_full;
  logic [NF-1:0] fifo_rden;
  logic [NF*8-1:0] fifo_rdata;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic [WW-1:0] rd_word;
  logic          rd_valid;
  fill_state_e   dbg_state;

  logic [WW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural environment state
  logic [7:0]    fmem [NF][16];
  int            wp [NF];
  int            rp [NF];
  logic [7:0]    wrec [NF][DEPTH];
  logic [NF-1:0] rd_pend;
  logic [7:0]    wr_byte;
  logic [NF-1:0] exp_wren;
  logic [AW-1:0] addr_log[$];
  bit fm_active, rand_data, stall_en, steer_chk;
  int fm_k, fm_gap, fm_cur, start_cnt, stall_idx, rdv_cnt;

  fifo_fill_sequencer #(
    .NUM_FIFOS(NF), .DEPTH(DEPTH), .ADDR_W(AW),
    .ADDR_BASE(32'd0), .ADDR_STRIDE(32'd1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .fill_done(fill_done),
    .timeout_err(timeout_err), .cur_idx(cur_idx), .filler_start(filler_start),
    .filler_address(filler_address), .filler_wren(filler_wren),
    .filler_done(filler_done), .filler_full(filler_full), .fifo_wren(fifo_wren),
    .fifo_full(fifo_full), .fifo_rden(fifo_rden), .fifo_rdata(fifo_rdata),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_word(rd_word), .rd_valid(rd_valid),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- filler + FIFO bank model (negedge) ----------------
  initial begin : env
    filler_wren = 1'b0; filler_done = 1'b0; wr_byte = '0; fifo_rdata = '0;
    rd_pend = '0; fm_active = 0; fm_k = 0; fm_gap = 0; fm_cur = 0; rdv_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fm_active = 0; filler_wren = 1'b0; filler_done = 1'b0; rd_pend = '0;
        continue;
      end
      if (filler_start) begin
        addr_log.push_back(filler_address);
        fm_cur = (start_cnt < NF) ? start_cnt : NF - 1;
        start_cnt++;
      end
      if (steer_chk && start_cnt > 0) begin
        exp_wren = filler_wren ? (NF'(1) << fm_cur) : '0;
        n_checks++;
        if (fifo_wren !== exp_wren) begin
          n_fail++;
          $display("FAIL steer_wren: got %b expected %b", fifo_wren, exp_wren);
        end
        n_checks++;
        if (filler_full !== fifo_full[fm_cur]) begin
          n_fail++;
          $display("FAIL steer_full: got %b expected %b (fifo %0d)", filler_full, fifo_full[fm_cur], fm_cur);
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (fifo_wren[i]) begin
          fmem[i][wp[i] % 16] = wr_byte;
          wp[i]++;
        end
        if (rd_pend[i]) begin
          fifo_rdata[8*i +: 8] = fmem[i][rp[i] % 16];
          rp[i]++;
        end
      end
      rd_pend = fifo_rden;
      if (rd_valid) rdv_cnt++;
      filler_wren = 1'b0;
      filler_done = 1'b0;
      if (filler_start) begin
        fm_active = 1; fm_k = 0; fm_gap = $urandom_range(0, 2);
      end else if (fm_active) begin
        if (fm_gap > 0) begin
          fm_gap--;
        end else if (fm_k < DEPTH) begin
          wr_byte = rand_data ? 8'($urandom) : {4'(fm_cur), 4'(DEPTH - fm_k)};
          wrec[fm_cur][fm_k] = wr_byte;
          filler_wren = 1'b1;
          fm_k++;
          fm_gap = $urandom_range(0, 1);
        end else begin
          if (!(stall_en && fm_cur == stall_idx)) filler_done = 1'b1;
          fm_active = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_pass();
    for (int i = 0; i < NF; i++) begin
      wp[i] = 0; rp[i] = 0;
    end
    start_cnt = 0;
    addr_log.delete();
    steer_chk = 1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    steer_chk = 0;
  endtask

  task automatic do_drain(input int idx, output int lat);
    rd_idx = IW'(idx);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [WW-1:0] packed_exp(input int idx);
    logic [WW-1:0] w;
    for (int k = 0; k < DEPTH; k++) w[8*k +: 8] = wrec[idx][k];
    return w;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({busy, fill_done, timeout_err, filler_start, filler_full, rd_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, fill_done, timeout_err, filler_start, filler_full, rd_valid});
    end
    n_checks++;
    if (cur_idx !== '0 || filler_address !== '0) begin
      n_fail++;
      $display("FAIL reset_idx: got idx %0d addr %0d expected 0 0", cur_idx, filler_address);
    end
    n_checks++;
    if (fifo_wren !== '0 || fifo_rden !== '0 || rd_word !== '0) begin
      n_fail++;
      $display("FAIL reset_vec: got wren %b rden %b word %h expected 0", fifo_wren, fifo_rden, rd_word);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal_fill();
    rand_data = 0;
    begin_pass();
    pulse_go();
    n_checks++;
    if (filler_start !== 1'b1 || busy !== 1'b1 || filler_address !== 32'd0) begin
      n_fail++;
      $display("FAIL nom_first_start: got start %b busy %b addr %0d expected 1 1 0",
               filler_start, busy, filler_address);
    end
    tick();
    n_checks++;
    if (filler_start !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_start_width: got %b expected 0", filler_start);
    end
    wait_idle(3000);
    n_checks++;
    if (addr_log.size() != NF) begin
      n_fail++;
      $display("FAIL nom_start_count: got %0d expected %0d", addr_log.size(), NF);
    end
    for (int k = 0; k < NF && k < addr_log.size(); k++) begin
      n_checks++;
      if (addr_log[k] !== AW'(k)) begin
        n_fail++;
        $display("FAIL nom_addr[%0d]: got %0d expected %0d", k, addr_log[k], k);
      end
    end
    n_checks++;
    if (fill_done !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_done: got done %b err %b busy %b expected 1 0 0", fill_done, timeout_err, busy);
    end
  endtask

  task automatic test_drain_all();
    int lat;
    logic [WW-1:0] w0, w8, e;
    w0 = 64'h0102030405060708;
    w8 = 64'h8182838485868788;
    for (int i = 0; i < NF; i++) begin
      exp_q.push_back(packed_exp(i));
      do_drain(i, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (rd_word !== e) begin
        n_fail++;
        $display("FAIL drain_word[%0d]: got %h expected %h", i, rd_word, e);
      end
      if (i == 0 || i == NF - 1) begin
        n_checks++;
        if (rd_word !== ((i == 0) ? w0 : w8)) begin
          n_fail++;
          $display("FAIL drain_const[%0d]: got %h expected %h", i, rd_word, (i == 0) ? w0 : w8);
        end
      end
      n_checks++;
      if (lat != DEPTH + 2) begin
        n_fail++;
        $display("FAIL drain_latency[%0d]: got %0d expected %0d", i, lat, DEPTH + 2);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_word !== e) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: got valid %b word %h expected 0 %h", i, rd_valid, rd_word, e);
      end
    end
  endtask

  task automatic test_random_fill_drain();
    int lat, idx;
    logic [WW-1:0] e;
    rand_data = 1;
    begin_pass();
    pulse_go();
    n_checks++;
    if (fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_done_clear: got %b expected 0", fill_done);
    end
    wait_idle(3000);
    n_checks++;
    if (fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rnd_done: got %b expected 1", fill_done);
    end
    for (int n = 0; n < 4; n++) begin
      idx = $urandom_range(0, NF - 1);
      for (int i = 0; i < NF; i++) rp[i] = 0;
      exp_q.push_back(packed_exp(idx));
      do_drain(idx, lat);
      e = exp_q.pop_front();
      n_checks++;
      if (rd_word !== e || lat != DEPTH + 2) begin
        n_fail++;
        $display("FAIL rnd_drain[%0d]: got %h lat %0d expected %h lat %0d", idx, rd_word, lat, e, DEPTH + 2);
      end
    end
    rand_data = 0;
  endtask

  task automatic test_steering();
    fifo_full = NF'(1) << 5;
    begin_pass();
    pulse_go();
    wait_idle(3000);
    n_checks++;
    if (fill_done !== 1'b1 || filler_full !== 1'b0) begin
      n_fail++;
      $display("FAIL steer_pass: got done %b full %b expected 1 0", fill_done, filler_full);
    end
    fifo_full = '0;
  endtask

  task automatic test_stall();
    int n, rv0;
    stall_en = 1; stall_idx = 3;
    begin_pass();
    pulse_go();
    n = 0;
    while (!(filler_start && cur_idx == 4'd3) && n < 1000) begin
      tick();
      n++;
    end
    n = 0;
    while (!timeout_err && n < 1200) begin
      tick();
      n++;
    end
    steer_chk = 0;
    n_checks++;
    if (n != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL stall_time: got %0d cycles from START expected %0d", n, TIMEOUT + 1);
    end
    n_checks++;
    if (cur_idx !== 4'd3 || busy !== 1'b0 || fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_state: got idx %0d busy %b done %b expected 3 0 0", cur_idx, busy, fill_done);
    end
    rv0 = rdv_cnt;
    rd_idx = 4'd0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (14) tick();
    n_checks++;
    if (rdv_cnt != rv0 || fifo_rden !== '0 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_rd_ignored: got valids %0d rden %b err %b expected %0d 0 1",
               rdv_cnt - rv0, fifo_rden, timeout_err, 0);
    end
    stall_en = 0;
    begin_pass();
    pulse_go();
    n_checks++;
    if (timeout_err !== 1'b0 || filler_start !== 1'b1 || filler_address !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_restart: got err %b start %b addr %0d expected 0 1 0",
               timeout_err, filler_start, filler_address);
    end
    wait_idle(3000);
    n_checks++;
    if (fill_done !== 1'b1 || start_cnt != NF) begin
      n_fail++;
      $display("FAIL stall_repass: got done %b starts %0d expected 1 %0d", fill_done, start_cnt, NF);
    end
  endtask

  task automatic test_collisions();
    int rv0;
    bit busy_seen;
    rv0 = rdv_cnt;
    begin_pass();
    go = 1'b1; rd_req = 1'b1; rd_idx = 4'd2;
    tick();
    go = 1'b0; rd_req = 1'b0;
    n_checks++;
    if (filler_start !== 1'b1 || fifo_rden !== '0) begin
      n_fail++;
      $display("FAIL coll_go_wins: got start %b rden %b expected 1 0", filler_start, fifo_rden);
    end
    repeat (40) tick();
    go = 1'b1; rd_req = 1'b1; rd_idx = 4'd1;
    tick();
    go = 1'b0; rd_req = 1'b0;
    wait_idle(3000);
    n_checks++;
    if (start_cnt != NF || rdv_cnt != rv0 || fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_busy_ignored: got starts %0d valids %0d done %b expected %0d 0 1",
               start_cnt, rdv_cnt - rv0, fill_done, NF);
    end
    rd_idx = 4'd9; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    busy_seen = busy;
    repeat (15) begin
      tick();
      busy_seen |= busy;
    end
    n_checks++;
    if (rdv_cnt != rv0 || busy_seen) begin
      n_fail++;
      $display("FAIL coll_bad_idx: got valids %0d busy %b expected 0 0", rdv_cnt - rv0, busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    begin_pass();
    pulse_go();
    repeat (5) tick();
    steer_chk = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, filler_start, fill_done, timeout_err} !== 4'b0 || fifo_wren !== '0 ||
        dbg_state !== ST_IDLE || cur_idx !== '0) begin
      n_fail++;
      $display("FAIL rst_wait: got busy %b start %b idx %0d state %0d expected all 0",
               busy, filler_start, cur_idx, dbg_state);
    end
    tick();
    rst_n = 1'b1;
    tick();
    begin_pass();
    pulse_go();
    wait_idle(3000);
    n_checks++;
    if (fill_done !== 1'b1 || start_cnt != NF) begin
      n_fail++;
      $display("FAIL rst_wait_repass: got done %b starts %0d expected 1 %0d", fill_done, start_cnt, NF);
    end
    rd_idx = 4'd4; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || fifo_rden !== '0 || rd_valid !== 1'b0 || rd_word !== '0 || fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain: got busy %b rden %b valid %b word %h done %b expected all 0",
               busy, fifo_rden, rd_valid, rd_word, fill_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    begin_pass();
    pulse_go();
    wait_idle(3000);
    n_checks++;
    if (fill_done !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain_repass: got done %b err %b expected 1 0", fill_done, timeout_err);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin : main
    go = 1'b0; rd_req = 1'b0; rd_idx = '0; fifo_full = '0; rst_n = 1'b0;
    rand_data = 0; stall_en = 0; stall_idx = 0; steer_chk = 0; start_cnt = 0;
    test_reset();
    test_nominal_fill();
    test_drain_all();
    test_random_fill_drain();
    test_steering();
    test_stall();
    test_collisions();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
